// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, BCD constants and integer-to-BCD helper
package traffic_pkg;
    localparam logic [1:0] ST_GREEN  = 2'd0;
    localparam logic [1:0] ST_YELLOW = 2'd1;
    localparam logic [1:0] ST_ALLRED = 2'd2;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [7:0] BCD_ZERO = 8'h00;
    localparam logic [7:0] BCD_ONE  = 8'h01;
    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction
endpackage

// File: rtl/bcd_down_counter2.sv
// bcd_down_counter2: two-digit BCD down counter with load, decrement and is-one flag
module bcd_down_counter2
    import traffic_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       dec_i,
    output logic [7:0] cnt_o,
    output logic       is_one_o
);
    logic [7:0] cnt_q, cnt_d;
    // load wins over decrement; units borrow from tens at zero, and 00 holds
    always_comb begin
        cnt_d = load_i ? load_val_i :
                (!dec_i || cnt_q == BCD_ZERO) ? cnt_q :
                (cnt_q[3:0] == 4'd0) ? {cnt_q[7:4] - 4'd1, BCD_MAX_DIGIT} :
                {cnt_q[7:4], cnt_q[3:0] - 4'd1};
    end
    // count register
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= RST_VAL;
        else cnt_q <= cnt_d;
    end
    assign cnt_o    = cnt_q;
    assign is_one_o = cnt_q == BCD_ONE;
endmodule

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: round-robin N-way green/yellow/all-red sequencer with BCD countdown
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int NUM_DIR       = 4,
    parameter int GREEN_TIME    = 30,
    parameter int YELLOW_TIME   = 3,
    parameter int ALLRED_TIME   = 1,
    parameter int MIN_GREEN     = 5,
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic               CLK,
    input  logic               R,
    input  logic [NUM_DIR-1:0] Traffic,
    input  logic               Man,
    input  logic [2:0]         Man_Sel,
    output logic [NUM_DIR-1:0] Green,
    output logic [NUM_DIR-1:0] Yellow,
    output logic [2:0]         Phase,
    output logic [3:0]         Time_H,
    output logic [3:0]         Time_L
);
    localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0] GREEN_BCD  = to_bcd(GREEN_TIME);
    localparam logic [7:0] YELLOW_BCD = to_bcd(YELLOW_TIME);
    localparam logic [7:0] ALLRED_BCD = to_bcd(ALLRED_TIME);
    localparam logic [7:0] SKIP_BCD   = to_bcd(GREEN_TIME - MIN_GREEN);

    logic [PW-1:0]      presc_q, presc_d;
    logic               tick;
    logic [1:0]         state_q, state_d;
    logic [2:0]         phase_q, phase_d;
    logic [2:0]         tgt_q, tgt_d;
    logic               tgt_vld_q, tgt_vld_d;
    logic [7:0]         cnt;
    logic               cnt_one;
    logic               load;
    logic [7:0]         load_val;
    logic               dec;
    logic [2:0]         rr_nxt;
    logic [2:0]         nxt;
    logic [NUM_DIR-1:0] onehot;
    logic               in_green;
    logic               sel_ok;
    logic               man_hold;
    logic               man_go;
    logic               skip;

    assign tick     = presc_q == PRESC_MAX;
    assign presc_d  = tick ? '0 : presc_q + PW'(1);
    assign onehot   = NUM_DIR'(1) << phase_q;
    assign in_green = state_q == ST_GREEN;
    assign sel_ok   = int'(Man_Sel) < NUM_DIR;
    assign man_hold = Man & in_green & (!sel_ok | Man_Sel == phase_q);
    assign man_go   = Man & in_green & sel_ok & Man_Sel != phase_q;
    assign skip     = ~|(Traffic & onehot) & |(Traffic & ~onehot) & (cnt <= SKIP_BCD);
    assign nxt      = (Man & sel_ok) ? Man_Sel : (Man & tgt_vld_q) ? tgt_q : rr_nxt;

    bcd_down_counter2 #(.RST_VAL(GREEN_BCD)) u_timer (
        .clk_i      (CLK),
        .rst_i      (R),
        .load_i     (load),
        .load_val_i (load_val),
        .dec_i      (dec),
        .cnt_o      (cnt),
        .is_one_o   (cnt_one)
    );

    // nearest demanding approach after the current one, scanning far-to-near so the closest wins
    always_comb begin
        rr_nxt = phase_q == 3'(NUM_DIR - 1) ? 3'd0 : phase_q + 3'd1;
        for (int k = NUM_DIR - 1; k >= 1; k--)
            if (|(Traffic & (NUM_DIR'(1) << ((int'(phase_q) + k) % NUM_DIR))))
                rr_nxt = 3'((int'(phase_q) + k) % NUM_DIR);
    end

    // state, phase, manual target and prescaler registers
    always_ff @(posedge CLK) begin
        if (R) begin
            presc_q   <= '0;
            state_q   <= ST_GREEN;
            phase_q   <= 3'd0;
            tgt_q     <= 3'd0;
            tgt_vld_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            state_q   <= state_d;
            phase_q   <= phase_d;
            tgt_q     <= tgt_d;
            tgt_vld_q <= tgt_vld_d;
        end
    end

    // next state and timer control; manual hold freezes green, otherwise expiry, manual cut or demand skip end it
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        tgt_d     = tgt_q;
        tgt_vld_d = tgt_vld_q & Man;
        load      = 1'b0;
        load_val  = GREEN_BCD;
        dec       = 1'b0;
        if (tick) begin
            case (state_q)
                ST_GREEN: begin
                    if (!man_hold) begin
                        if (cnt_one || man_go || skip) begin
                            state_d  = ST_YELLOW;
                            load     = 1'b1;
                            load_val = YELLOW_BCD;
                            if (man_go) begin
                                tgt_d     = Man_Sel;
                                tgt_vld_d = 1'b1;
                            end
                        end else begin
                            dec = 1'b1;
                        end
                    end
                end
                ST_YELLOW: begin
                    state_d  = cnt_one ? ST_ALLRED : ST_YELLOW;
                    load     = cnt_one;
                    load_val = ALLRED_BCD;
                    dec      = !cnt_one;
                end
                ST_ALLRED: begin
                    if (cnt_one) begin
                        state_d   = ST_GREEN;
                        phase_d   = nxt;
                        tgt_vld_d = 1'b0;
                        load      = 1'b1;
                        load_val  = GREEN_BCD;
                    end else begin
                        dec = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_GREEN;
                    load     = 1'b1;
                    load_val = GREEN_BCD;
                end
            endcase
        end
    end

    // lamp and display outputs decoded from registered state
    always_comb begin
        Green  = in_green ? onehot : '0;
        Yellow = state_q == ST_YELLOW ? onehot : '0;
        Phase  = phase_q;
        {Time_H, Time_L} = cnt;
    end
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: scoreboard bench driving a behavioural model alongside the controller
module tb_traffic_phase_controller;
    localparam int N  = 4;
    localparam int GT = 30;
    localparam int YT = 3;
    localparam int AT = 1;
    localparam int MG = 5;

    logic       CLK = 1'b0;
    logic       R;
    logic [3:0] Traffic;
    logic       Man;
    logic [2:0] Man_Sel;
    logic [3:0] Green;
    logic [3:0] Yellow;
    logic [2:0] Phase;
    logic [3:0] Time_H;
    logic [3:0] Time_L;

    always #5 CLK = ~CLK;

    traffic_phase_controller #(
        .NUM_DIR(N), .GREEN_TIME(GT), .YELLOW_TIME(YT), .ALLRED_TIME(AT),
        .MIN_GREEN(MG), .TICKS_PER_SEC(1)
    ) dut (
        .CLK(CLK), .R(R), .Traffic(Traffic), .Man(Man), .Man_Sel(Man_Sel),
        .Green(Green), .Yellow(Yellow), .Phase(Phase), .Time_H(Time_H), .Time_L(Time_L)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] y;
        logic [2:0] ph;
        logic [7:0] t;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   m_st, m_ph, m_t, m_tgt;
    bit   m_tv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    function automatic bit dem(input int j);
        return 1'(Traffic >> j);
    endfunction

    task automatic model();
        int   nxt;
        bit   tv, hold, go, skp, found;
        exp_t e;
        if (R) begin
            m_st = 0; m_ph = 0; m_t = GT; m_tv = 0;
        end else begin
            tv = m_tv && Man;
            if (m_st == 0) begin
                hold = Man && (int'(Man_Sel) == m_ph || int'(Man_Sel) >= N);
                go   = Man && int'(Man_Sel) < N && int'(Man_Sel) != m_ph;
                skp  = !dem(m_ph) && (Traffic & ~(4'b0001 << m_ph)) != 4'b0000 && m_t <= GT - MG;
                if (!hold) begin
                    if (m_t == 1 || go || skp) begin
                        m_st = 1; m_t = YT;
                        if (go) begin m_tgt = int'(Man_Sel); tv = 1; end
                    end else m_t--;
                end
            end else if (m_st == 1) begin
                if (m_t == 1) begin m_st = 2; m_t = AT; end else m_t--;
            end else begin
                if (m_t == 1) begin
                    nxt = (m_ph + 1) % N;
                    found = 0;
                    for (int k = 1; k < N; k++)
                        if (!found && dem((m_ph + k) % N)) begin nxt = (m_ph + k) % N; found = 1; end
                    if (Man && int'(Man_Sel) < N) nxt = int'(Man_Sel);
                    else if (tv) nxt = m_tgt;
                    m_st = 0; m_t = GT; m_ph = nxt; tv = 0;
                end else m_t--;
            end
            m_tv = tv;
        end
        e.g  = m_st == 0 ? 4'(1 << m_ph) : 4'b0000;
        e.y  = m_st == 1 ? 4'(1 << m_ph) : 4'b0000;
        e.ph = 3'(m_ph);
        e.t  = {4'(m_t / 10), 4'(m_t % 10)};
        sb.push_back(e);
    endtask

    task automatic step(input int n = 1);
        exp_t e;
        repeat (n) begin
            model();
            @(posedge CLK);
            #1;
            chk("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("green", Green, e.g);
                chk("yellow", Yellow, e.y);
                chk("phase", Phase, e.ph);
                chk("time", {Time_H, Time_L}, e.t);
                chk("excl", Green != 0 && Yellow != 0, 0);
                chk("onehot", $countones(Green) <= 1 && $countones(Yellow) <= 1, 1);
                chk("bcd", Time_H <= 9 && Time_L <= 9, 1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        R = 1'b1; Traffic = 4'hF; Man = 1'b0; Man_Sel = 3'd0;
        step(2);
        chk("rst_time", {Time_H, Time_L}, 8'h30);
        chk("rst_green", Green, 4'b0001);
        chk("rst_phase", Phase, 0);
        R = 1'b0;
        for (int p = 1; p <= 4; p++) begin
            step(34);
            chk("rr_phase", Phase, 3'(p % 4));
        end
        R = 1'b1; step(); R = 1'b0;
        Traffic = 4'b0100;
        step(5);
        chk("skip_25", {Time_H, Time_L}, 8'h25);
        chk("skip_still_g", Green, 4'b0001);
        step();
        chk("skip_yellow", Yellow, 4'b0001);
        step(4);
        chk("skip_phase", Phase, 2);
        chk("skip_green", Green, 4'b0100);
        Traffic = 4'b0000;
        step(30);
        chk("y_phase2", Yellow, 4'b0100);
        R = 1'b1; step();
        chk("rmid_phase", Phase, 0);
        chk("rmid_green", Green, 4'b0001);
        chk("rmid_time", {Time_H, Time_L}, 8'h30);
        R = 1'b0;
        step(10);
        chk("borrow_20", {Time_H, Time_L}, 8'h20);
        step();
        chk("borrow_19", {Time_H, Time_L}, 8'h19);
        step(9);
        chk("borrow_10", {Time_H, Time_L}, 8'h10);
        step();
        chk("borrow_09", {Time_H, Time_L}, 8'h09);
        step(8);
        chk("nd_01", {Time_H, Time_L}, 8'h01);
        chk("nd_green", Green, 4'b0001);
        step();
        chk("nd_yellow", Yellow, 4'b0001);
        step(4);
        chk("nd_phase", Phase, 1);
        R = 1'b1; step(); R = 1'b0;
        Traffic = 4'hF;
        step(2);
        chk("man_28", {Time_H, Time_L}, 8'h28);
        Man = 1'b1; Man_Sel = 3'd3;
        step();
        chk("man_yellow", Yellow, 4'b0001);
        step(3);
        chk("man_allred", {Green, Yellow}, 8'h00);
        step();
        chk("man_green3", Green, 4'b1000);
        chk("man_phase3", Phase, 3);
        step(5);
        chk("man_frozen", {Time_H, Time_L}, 8'h30);
        Man_Sel = 3'd7;
        step(3);
        chk("man_inv_hold", {Time_H, Time_L}, 8'h30);
        chk("man_inv_green", Green, 4'b1000);
        Man = 1'b0;
        step();
        chk("rel_29", {Time_H, Time_L}, 8'h29);
        step();
        chk("rel_28", {Time_H, Time_L}, 8'h28);
        Man = 1'b1; Man_Sel = 3'd1;
        step();
        chk("chg_yellow", Yellow, 4'b1000);
        Man_Sel = 3'd2;
        step(4);
        chk("chg_phase", Phase, 2);
        step(3);
        chk("chg_hold", {Time_H, Time_L}, 8'h30);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
